// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state type and width helpers for the sequential ALU.
package seq_alu_pkg;

  localparam int unsigned OP_W     = 5;
  localparam int unsigned MAX_XLEN = 128;

  localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] OP_SLL    = 5'b00001;
  localparam logic [OP_W-1:0] OP_SLT    = 5'b00010;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR    = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRL    = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR     = 5'b00110;
  localparam logic [OP_W-1:0] OP_AND    = 5'b00111;
  localparam logic [OP_W-1:0] OP_SUB    = 5'b01000;
  localparam logic [OP_W-1:0] OP_SRA    = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL    = 5'b10000;
  localparam logic [OP_W-1:0] OP_MULH   = 5'b10001;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'b10010;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'b10011;
  localparam logic [OP_W-1:0] OP_DIV    = 5'b10100;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'b10101;
  localparam logic [OP_W-1:0] OP_REM    = 5'b10110;
  localparam logic [OP_W-1:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Most negative two's-complement value of width w, truncated by the caller.
  function automatic logic [MAX_XLEN-1:0] xlen_min(input int unsigned w);
    return MAX_XLEN'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between the issuing stage and seq_alu.
interface seq_alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            is_zero;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, is_zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, is_zero, busy
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide engine sharing one 2*XLEN shift accumulator.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last_c,
  output logic [XLEN-1:0] res_c
);
  localparam int unsigned     CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN  = XLEN'(xlen_min(XLEN));
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2:0]        fn3_q, fn3_d;
  logic              neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, ovf_q, ovf_d;

  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     mul_sum, div_top, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mul_res;

  // Operand magnitudes and sign flags, signedness decoded from funct3.
  always_comb begin
    a_sgn = fn3[2] ? ~fn3[0] : (fn3[1:0] == 2'b01 || fn3[1:0] == 2'b10);
    b_sgn = fn3[2] ? ~fn3[0] : (fn3[1:0] == 2'b01);
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    ma    = sa ? -a : a;
    mb    = sb ? -b : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opd_q} & {(XLEN+1){acc_q[0]}});
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = div_top >= {1'b0, opd_q};
    div_diff = div_top - {1'b0, opd_q};
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    opd_d = opd_q;
    fn3_d = fn3_q;
    neg_d = neg_q;
    sa_d  = sa_q;
    dz_d  = dz_q;
    ovf_d = ovf_q;
    if (start) begin
      cnt_d = CW'(XLEN - 1);
      fn3_d = fn3;
      neg_d = sa ^ sb;
      sa_d  = sa;
      opd_d = fn3[2] ? mb : ma;
      acc_d = {{XLEN{1'b0}}, fn3[2] ? ma : mb};
      dz_d  = fn3[2] && (b == '0);
      ovf_d = fn3[2] && !fn3[0] && (a == MIN) && (b == ONES);
    end else if (step) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (fn3_q[2])
        acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
      else
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  assign last_c = step && (cnt_q == '0);

  // Sign correction and half / quotient-remainder selection.
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    mul_res = (fn3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo     = dz_q  ? ONES : ovf_q ? MIN :
              (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem     = ovf_q ? '0 : (sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]);
    res_c   = fn3_q[2] ? (fn3_q[1] ? rem : quo) : mul_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      fn3_q <= '0;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      fn3_q <= fn3_d;
      neg_q <= neg_d;
      sa_q  <= sa_d;
      dz_q  <= dz_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked RV32I/M ALU: single-cycle base ops, iterative multiply/divide via seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_zero_q, is_zero_d;
  logic            busy_q, busy_d;

  logic            in_ready_c, accept_c, md_start_c, md_last_c;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res_c, md_res_c;

  assign shamt = bus.b[SHW-1:0];

  always_comb begin
    base_res_c = '0;
    case (bus.op)
      OP_ADD:  base_res_c = bus.a + bus.b;
      OP_SUB:  base_res_c = bus.a - bus.b;
      OP_SLL:  base_res_c = bus.a << shamt;
      OP_SRL:  base_res_c = bus.a >> shamt;
      OP_SRA:  base_res_c = XLEN'($signed(bus.a) >>> shamt);
      OP_SLT:  base_res_c = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: base_res_c = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      OP_XOR:  base_res_c = bus.a ^ bus.b;
      OP_OR:   base_res_c = bus.a | bus.b;
      OP_AND:  base_res_c = bus.a & bus.b;
      default: base_res_c = '0;
    endcase
  end

  assign in_ready_c = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    md_start_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept_c) begin
          if (bus.op[4]) begin
            state_d     = ST_CALC;
            out_valid_d = 1'b0;
            md_start_c  = 1'b1;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = base_res_c;
          end
        end
      end
      ST_CALC: if (md_last_c) state_d = ST_FIX;
      ST_FIX: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        result_d    = md_res_c;
      end
      default: state_d = ST_IDLE;
    endcase
    is_zero_d = (result_d == '0);
    busy_d    = (state_d == ST_CALC) || (state_d == ST_FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      is_zero_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      is_zero_q   <= is_zero_d;
      busy_q      <= busy_d;
    end
  end

  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_c),
    .step   (state_q == ST_CALC),
    .fn3    (bus.op[2:0]),
    .a      (bus.a),
    .b      (bus.b),
    .last_c (md_last_c),
    .res_c  (md_res_c)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.is_zero   = is_zero_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at issue, checked at output transfer.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  seq_alu_if #(.XLEN(32)) bus ();

  seq_alu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Compare each transferred result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("result", bus.result, e);
        chk("is_zero", 32'(bus.is_zero), 32'(e == 32'd0));
      end
    end
  end

  // Drive a request and hold it until accepted; returns the number of stalled cycles.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push, output int waits);
    bit ok;
    ok       = 1'b0;
    waits    = 0;
    bus.in_valid = 1'b1;
    bus.op   = op;
    bus.a    = a;
    bus.b    = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a  = '0;
    bus.b  = '0;
  endtask

  // Measure accept-to-out_valid latency; for M ops also watch busy/in_ready while computing.
  task automatic wait_lat(input string tag, input int exp_lat, input bit m_op);
    int lat;
    bit side_ok;
    lat     = 1;
    side_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (m_op && (!bus.busy || bus.in_ready)) side_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
    if (m_op) chk({tag, "_busy"}, 32'(side_ok), 32'd1);
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int w;
    issue(op, a, b, exp, 1'b1, w);
    idle_in();
    wait_lat(tag, op[4] ? 34 : 1, op[4]);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    idle_in();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_is_zero", 32'(bus.is_zero), 32'd1);

    run("lat_add", OP_ADD, 32'd7, 32'd5, 32'd12);
    run("lat_sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run("lat_sra", OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000);
    run("lat_zero", OP_SUB, 32'd3, 32'd3, 32'd0);
    run("lat_sll", OP_SLL, 32'h0000_0003, 32'h24, 32'h0000_0030);
    run("lat_slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run("lat_sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run("lat_xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
    run("lat_bad", 5'b01001, 32'd9, 32'd9, 32'd0);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(OP_ADD, 32'(i * 3), 32'(100 + i), 32'(i * 3 + 100 + i), 1'b1, w);
      if (i > 0) chk("b2b_in_ready", 32'(w), 32'd0);
    end
    idle_in();
    drain();

    run("lat_mul", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run("lat_mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("lat_mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("lat_mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("lat_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("lat_rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("lat_divu0", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF);
    run("lat_remu0", OP_REMU, 32'd9, 32'd0, 32'd9);
    run("lat_div0s", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run("lat_divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("lat_removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("lat_divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    drain();

    bus.out_ready = 1'b0;
    run("lat_bp", OP_ADD, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", bus.result, 32'h1234_5678);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(bus.out_valid), 32'd0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    issue(OP_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, w);
    idle_in();
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run("lat_post_rst", OP_ADD, 32'd40, 32'd2, 32'd42);
    drain();
    repeat (40) @(posedge clk);
    #1;
    chk("no_stale_output", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
